// File: rtl/maxpool_ctrl.sv
// rtl/maxpool_ctrl.sv - windowed max-pool sequencing controller; define MAXPOOL_SIGNED_EN for signed compare
module maxpool_ctrl #(
    parameter int DATA_W = 4,
    parameter int WIN    = 4,
    parameter int CNT_W  = $clog2(WIN)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        num_win,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        EMIT = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ELEM = CNT_W'(WIN - 1);

    state_t            state;
    logic [CNT_W-1:0]  elem_cnt;
    logic [7:0]        win_cnt;
    logic [7:0]        num_win_r;
    logic [DATA_W-1:0] max_r;
    logic              greater;
    logic [DATA_W-1:0] next_max;
    logic              last_win;

    // Strictly-greater compare so a tie keeps the current maximum.
`ifdef MAXPOOL_SIGNED_EN
    assign greater = $signed(in_data) > $signed(max_r);
`else
    assign greater = in_data > max_r;
`endif

    // The first element of each window reseeds the maximum, so no stale value survives.
    assign next_max = ((elem_cnt == '0) || greater) ? in_data : max_r;
    assign last_win = (win_cnt == (num_win_r - 8'd1));

    // Ready depends on state alone, never on in_valid.
    assign in_ready = (state == ACC);

    // Frame sequencing FSM with registered out_valid/out_data/busy/done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            elem_cnt  <= '0;
            win_cnt   <= '0;
            num_win_r <= '0;
            max_r     <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && (num_win != 8'd0)) begin
                        num_win_r <= num_win;
                        elem_cnt  <= '0;
                        win_cnt   <= '0;
                        busy      <= 1'b1;
                        state     <= ACC;
                    end
                end
                ACC: begin
                    if (in_valid) begin
                        max_r <= next_max;
                        if (elem_cnt == LAST_ELEM) begin
                            out_data  <= next_max;
                            out_valid <= 1'b1;
                            elem_cnt  <= '0;
                            state     <= EMIT;
                        end else begin
                            elem_cnt <= elem_cnt + CNT_W'(1);
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        win_cnt   <= win_cnt + 8'd1;
                        if (last_win) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state <= ACC;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_maxpool_ctrl.sv
// tb/tb_maxpool_ctrl.sv - self-checking bench for maxpool_ctrl
module tb_maxpool_ctrl;

    localparam int DATA_W = 4;
    localparam int WIN    = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [7:0]        num_win = 8'd0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready = 1'b0;
    logic              busy;
    logic              done;

    int n_assert = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] stim[$];

    always #5 clk = ~clk;

    maxpool_ctrl #(.DATA_W(DATA_W), .WIN(WIN)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_win  (num_win),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .busy     (busy),
        .done     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int val(input logic [DATA_W-1:0] x);
        int v;
`ifdef MAXPOOL_SIGNED_EN
        v = $signed(x);
`else
        v = int'(x);
`endif
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] ref_max(input int base);
        int best_i;
        best_i = base;
        for (int k = 1; k < WIN; k++)
            if (val(stim[base + k]) > val(stim[best_i])) best_i = base + k;
        return stim[best_i];
    endfunction

    task automatic push4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [3:0] d);
        stim.delete();
        stim.push_back(a);
        stim.push_back(b);
        stim.push_back(c);
        stim.push_back(d);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"},  in_ready,  0);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_data"},  out_data,  0);
        chk({tag, "_busy"},      busy,      0);
        chk({tag, "_done"},      done,      0);
    endtask

    // Runs a whole frame from stim[], checking every window against the reference model.
    task automatic run_frame(input int nw, input int gap, input int bp, input bit mid_start);
        int idx;
        logic [DATA_W-1:0] expv;
        idx = 0;
        start   = 1'b1;
        num_win = 8'(nw);
        tick();
        start   = 1'b0;
        num_win = 8'd0;
        chk("busy_after_start", busy, 1);
        for (int w = 0; w < nw; w++) begin
            expv = ref_max(w * WIN);
            for (int e = 0; e < WIN; e++) begin
                for (int g = 0; g < gap; g++) begin
                    in_valid = 1'b0;
                    tick();
                    chk("in_ready_gap", in_ready, 1);
                end
                chk("in_ready_acc", in_ready, 1);
                chk("out_valid_acc", out_valid, 0);
                in_valid = 1'b1;
                in_data  = stim[idx];
                idx++;
                if (mid_start && w == 0 && e == 1) begin
                    start   = 1'b1;
                    num_win = 8'd7;
                end
                tick();
                start    = 1'b0;
                num_win  = 8'd0;
                in_valid = 1'b0;
            end
            chk("out_valid_emit", out_valid, 1);
            chk("out_data", out_data, expv);
            chk("in_ready_emit", in_ready, 0);
            for (int b = 0; b < bp; b++) begin
                in_valid = 1'b1;
                in_data  = ~expv;
                tick();
                chk("bp_out_valid", out_valid, 1);
                chk("bp_out_data", out_data, expv);
                chk("bp_in_ready", in_ready, 0);
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            chk("done_at_handshake", done, (w == nw - 1) ? 1 : 0);
            chk("busy_at_handshake", busy, (w == nw - 1) ? 0 : 1);
            chk("out_valid_after", out_valid, 0);
            chk("out_data_hold", out_data, expv);
        end
        tick();
        chk("done_single_pulse", done, 0);
        chk("busy_idle", busy, 0);
        chk("in_ready_idle", in_ready, 0);
    endtask

    initial begin
        // Reset values, and in_ready stays low without start.
        in_valid = 1'b1;
        #1;
        chk_reset_outputs("por");
        tick();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("no_start_in_ready", in_ready, 0);
            chk("no_start_busy", busy, 0);
        end
        in_valid = 1'b0;

        // Single window, then reseed with backpressure, then input gaps.
        push4(4'd3, 4'd9, 4'd2, 4'd7);
        chk("model_single", ref_max(0), 9);
        run_frame(1, 0, 0, 1'b0);

        push4(4'd8, 4'd8, 4'd8, 4'd8);
        stim.push_back(4'd2);
        stim.push_back(4'd1);
        stim.push_back(4'd0);
        stim.push_back(4'd3);
        run_frame(2, 0, 5, 1'b0);

        push4(4'd1, 4'd15, 4'd4, 4'd0);
        run_frame(1, 2, 0, 1'b0);

        // Start with num_win=0 is ignored.
        start   = 1'b1;
        num_win = 8'd0;
        tick();
        start = 1'b0;
        chk("zero_start_busy", busy, 0);
        chk("zero_start_in_ready", in_ready, 0);
        tick();
        chk("zero_start_done", done, 0);

        // Start pulsed mid-frame is ignored.
        push4(4'd6, 4'd2, 4'd11, 4'd5);
        run_frame(1, 0, 1, 1'b1);

        // Asynchronous reset while holding a result in EMIT.
        push4(4'd5, 4'd6, 4'd7, 4'd2);
        start   = 1'b1;
        num_win = 8'd1;
        tick();
        start = 1'b0;
        for (int e = 0; e < WIN; e++) begin
            in_valid = 1'b1;
            in_data  = stim[e];
            tick();
        end
        in_valid = 1'b0;
        chk("pre_reset_out_valid", out_valid, 1);
        chk("pre_reset_out_data", out_data, 7);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_emit");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();

        // Reset after two elements, then a fresh frame.
        start   = 1'b1;
        num_win = 8'd1;
        tick();
        start = 1'b0;
        for (int e = 0; e < 2; e++) begin
            in_valid = 1'b1;
            in_data  = 4'd15;
            tick();
        end
        in_valid = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_acc");
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick();
        chk("after_abort_done", done, 0);
        push4(4'd1, 4'd2, 4'd3, 4'd4);
        run_frame(1, 0, 0, 1'b0);

        // Sign-dependent window.
        push4(4'hF, 4'h8, 4'h1, 4'h9);
`ifdef MAXPOOL_SIGNED_EN
        chk("model_signed", ref_max(0), 4'h1);
`else
        chk("model_unsigned", ref_max(0), 4'hF);
`endif
        run_frame(1, 0, 0, 1'b0);

        // Randomized frames.
        for (int r = 0; r < 8; r++) begin
            int nw;
            nw = $urandom_range(1, 3);
            stim.delete();
            for (int i = 0; i < nw * WIN; i++) stim.push_back(DATA_W'($urandom));
            run_frame(nw, $urandom_range(0, 2), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
